// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for N requesters with registered one-hot and binary grant outputs.
// A grant is held while its requester keeps req high, bounded by MAX_HOLD cycles when others wait.
module rr_encoder_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             preempt
);

    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [IDX_W-1:0] ptr_q,      ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]     grant_q,    grant_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic             valid_q,    valid_d;
    logic             preempt_q,  preempt_d;

    // First set bit of r scanning start, start+1, ... modulo N; MSB flags a hit.
    function automatic logic [IDX_W:0] rr_search(input logic [N-1:0] r,
                                                 input logic [IDX_W-1:0] start);
        logic             found;
        logic [IDX_W-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned p;
            p = (32'(start) + i) % N;
            if (!found && r[IDX_W'(p)]) begin
                found = 1'b1;
                win   = IDX_W'(p);
            end
        end
        return {found, win};
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
        return (k == LAST_IDX) ? '0 : k + 1'b1;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] k);
        return {{(N-1){1'b0}}, 1'b1} << k;
    endfunction

    logic             req_k;
    logic [N-1:0]     others;
    logic [IDX_W-1:0] k_next;
    logic [IDX_W:0]   srch_idle;
    logic [IDX_W:0]   srch_rel;
    logic [IDX_W:0]   srch_pre;

    always_comb begin
        req_k     = |(req & grant_q);
        others    = req & ~grant_q;
        k_next    = next_idx(idx_q);
        srch_idle = rr_search(req, ptr_q);
        srch_rel  = rr_search(req, k_next);
        srch_pre  = rr_search(others, k_next);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        preempt_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d    = ST_BUSY;
                    grant_d    = onehot(srch_idle[IDX_W-1:0]);
                    idx_d      = srch_idle[IDX_W-1:0];
                    valid_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (!req_k) begin
                    // Release: req[k] is already low, so the full vector competes from k+1.
                    ptr_d = k_next;
                    if (srch_rel[IDX_W]) begin
                        grant_d    = onehot(srch_rel[IDX_W-1:0]);
                        idx_d      = srch_rel[IDX_W-1:0];
                        hold_cnt_d = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        grant_d    = '0;
                        valid_d    = 1'b0;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q == HOLD_MAX && |others) begin
                    ptr_d      = k_next;
                    grant_d    = onehot(srch_pre[IDX_W-1:0]);
                    idx_d      = srch_pre[IDX_W-1:0];
                    hold_cnt_d = '0;
                    preempt_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Self-checking bench for rr_encoder_arbiter: directed scenarios plus random traffic
// compared each cycle against a holder/pointer/tenure reference model.
module tb_rr_encoder_arbiter;

    localparam int N        = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             preempt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who holds the resource, where the next search starts, how long held.
    int m_holder;
    int m_ptr;
    int m_ten;
    int m_idx;
    bit m_pre;

    rr_encoder_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .preempt    (preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] r, input int p);
        return ((r >> p) & 8'h01) != 0;
    endfunction

    function automatic int m_search(input logic [N-1:0] r, input int from);
        for (int i = 0; i < N; i++) begin
            int p;
            p = (from + i) % N;
            if (bit_of(r, p)) return p;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_holder = -1;
        m_ptr    = 0;
        m_ten    = 0;
        m_idx    = 0;
        m_pre    = 0;
    endtask

    task automatic m_update(input logic [N-1:0] r);
        int w;
        m_pre = 0;
        if (m_holder < 0) begin
            w = m_search(r, m_ptr);
            if (w >= 0) begin
                m_holder = w;
                m_idx    = w;
                m_ten    = 0;
            end
        end else if (!bit_of(r, m_holder)) begin
            m_ptr = (m_holder + 1) % N;
            w = m_search(r, m_ptr);
            m_holder = w;
            m_ten    = 0;
            if (w >= 0) m_idx = w;
        end else begin
            logic [N-1:0] oth;
            oth = r & ~(8'h01 << m_holder);
            if (m_ten == MAX_HOLD - 1 && oth != 0) begin
                m_ptr    = (m_holder + 1) % N;
                w        = m_search(oth, m_ptr);
                m_holder = w;
                m_idx    = w;
                m_ten    = 0;
                m_pre    = 1;
            end else if (m_ten < MAX_HOLD - 1) begin
                m_ten++;
            end
        end
    endtask

    function automatic logic [N-1:0] m_grant();
        return (m_holder < 0) ? 8'h00 : (8'h01 << m_holder);
    endfunction

    task automatic check_outputs();
        chk("grant", grant, m_grant());
        chk("grant_idx", grant_idx, m_idx);
        chk("grant_valid", grant_valid, m_holder >= 0);
        chk("preempt", preempt, m_pre);
        chk("onehot0", $onehot0(grant), 1);
        if (grant_valid) chk("idx_consistent", grant, 8'h01 << grant_idx);
    endtask

    task automatic step();
        @(posedge clk);
        m_update(req);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_idx", grant_idx, 0);
        chk("rst_valid", grant_valid, 0);
        chk("rst_preempt", preempt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        int cnt2;
        int npre;
        m_reset();

        // 1: reset with all requests, first grant one cycle after release.
        req = 8'hFF;
        do_reset();
        step();
        chk("t1_grant", grant, 8'h01);
        chk("t1_idx", grant_idx, 0);
        chk("t1_valid", grant_valid, 1);

        // 2: each holder drops for one cycle -> 1..7,0 back to back.
        for (int i = 1; i <= N; i++) begin
            req = 8'hFF & ~grant;
            step();
            chk("t2_order", grant_idx, i % N);
            chk("t2_nobubble", grant_valid, 1);
        end

        // 3: req[2] and req[5] held -> 16 cycles of idx 2, preempt, then idx 5.
        req = 8'h00;
        do_reset();
        req = 8'h24;
        cnt2 = 0;
        npre = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (grant_valid && grant_idx == 2) cnt2++;
            if (preempt) begin
                npre++;
                chk("t3_rotated", grant_idx, 5);
            end
        end
        chk("t3_hold_cycles", cnt2, 16);
        chk("t3_preempts", npre, 1);
        chk("t3_final", grant_idx, 5);

        // 4: lone requester never preempted; a newcomer rotates on the next edge.
        req = 8'h00;
        do_reset();
        req = 8'h80;
        npre = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (preempt) npre++;
        end
        chk("t4_no_preempt", npre, 0);
        chk("t4_idx", grant_idx, 7);
        req = 8'h81;
        step();
        chk("t4_rotate_idx", grant_idx, 0);
        chk("t4_rotate_pre", preempt, 1);

        // 5: release of 7 wraps to 0; release with nothing pending goes idle.
        req = 8'h00;
        do_reset();
        req = 8'h80;
        step();
        req = 8'h01;
        step();
        chk("t5_wrap", grant_idx, 0);
        req = 8'h00;
        step();
        chk("t5_idle_grant", grant, 0);
        chk("t5_idle_valid", grant_valid, 0);
        chk("t5_idx_held", grant_idx, 0);

        // 6: asynchronous reset between edges clears outputs immediately.
        req = 8'h0F;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_grant", grant, 0);
        chk("t6_async_valid", grant_valid, 0);
        chk("t6_async_idx", grant_idx, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        req = 8'h30;
        step();
        chk("t6_restart", grant_idx, 4);

        // Random traffic with sticky requests and frequent holder releases.
        req = 8'h00;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            r = req;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 9) == 0) r = r ^ (8'h01 << b);
            if (grant_valid && $urandom_range(0, 5) == 0) r = r & ~grant;
            if ($urandom_range(0, 99) == 0) r = 8'h00;
            req = r;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
